fruit_template_scorer: RTL

//  Streams one 2048-byte binarized feature frame from the ISP and reads the matching fruit

---
 rtl/fruit_isp_pkg.sv | 16 +
 rtl/word_popcount.sv | 17 +
 rtl/fruit_template_scorer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fruit_isp_pkg.sv
// Shared definitions for the fruit template scorers and their ROM wrappers:
// default geometry and the scorer FSM state encoding.
package fruit_isp_pkg;

  localparam int ADDR_WIDTH_DEF  = 11;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int SCORE_WIDTH_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scorer_state_t;

endpackage

// File: rtl/word_popcount.sv
// Combinational population count of one data word.
module word_popcount #(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count = count + CNT_WIDTH'(word[i]);
    end
  end

endmodule

// File: rtl/fruit_template_scorer.sv
// Scores one streamed feature frame against a template ROM by counting agreeing
// bits (XNOR popcount) and flags whether the score reaches a latched threshold.
module fruit_template_scorer
  import fruit_isp_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SCORE_WIDTH = SCORE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  feat_data,
  input  logic                   feat_valid,
  output logic                   feat_ready,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  input  logic [SCORE_WIDTH-1:0] match_thresh,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   match,
  output logic [1:0]             state_dbg
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  // Handshake: a feature word transfers in any cycle where feat_valid and
  // feat_ready are both high; feat_ready depends only on registered state, and
  // the producer must hold feat_data stable while feat_valid is high and not accepted.

  scorer_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [SCORE_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]  feat_q;
  logic                   feat_q_vld;
  logic [SCORE_WIDTH-1:0] thresh_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   match_q;

  logic                   accept;
  logic                   last_word;
  logic                   start_ok;
  logic [DATA_WIDTH-1:0]  agree;
  logic [CNT_WIDTH-1:0]   agree_cnt;
  logic [SCORE_WIDTH-1:0] acc_sum;

  assign accept    = feat_valid & feat_ready;
  assign last_word = (idx_q == ADDR_WIDTH'(NUM_WORDS - 1));
  assign start_ok  = start & (state_q == S_IDLE);

  // ROM data lines up with the word registered one cycle earlier.
  assign agree = ~(rom_data ^ feat_q);

  word_popcount #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_popcount (
    .word  (agree),
    .count (agree_cnt)
  );

  assign acc_sum = feat_q_vld ? (acc_q + SCORE_WIDTH'(agree_cnt)) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)                 state_d = S_RUN;
      S_RUN:   if (accept && last_word)   state_d = S_DRAIN;
      S_DRAIN:                            state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    feat_ready = (state_q == S_RUN);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      acc_q      <= '0;
      feat_q     <= '0;
      feat_q_vld <= 1'b0;
      thresh_q   <= '0;
      score_q    <= '0;
      match_q    <= 1'b0;
    end else if (start_ok) begin
      idx_q      <= '0;
      acc_q      <= '0;
      feat_q_vld <= 1'b0;
      thresh_q   <= match_thresh;
    end else begin
      feat_q_vld <= accept;
      if (accept) begin
        feat_q <= feat_data;
        if (!last_word) begin
          idx_q <= idx_q + 1'b1;
        end
      end
      acc_q <= acc_sum;
      // The final word is folded in during DRAIN, so publish that sum directly.
      if (state_q == S_DRAIN) begin
        score_q <= acc_sum;
        match_q <= (acc_sum >= thresh_q);
      end
    end
  end

  assign rom_addr  = idx_q;
  assign score     = score_q;
  assign match     = match_q;
  assign state_dbg = state_q;

endmodule
